expr_lane_pipe: RTL

- Parametrised, pipelined successor to the combinational mixed-signedness expression blocks.
- Evaluates one operation per lane across LANES independent lanes, with operands up to WIDTH bits and per-operand signedness.
- Adds a valid/ready handshake, a 2-stage pipeline with backpressure, per-lane overflow flags and a transaction counter.
- Sits between the operand sequencer and the result packer in the expression regression datapath.

---
 rtl/expr_lane_pipe_if.sv | 37 +++
 rtl/expr_lane_pipe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/expr_lane_pipe_if.sv
// expr_lane_pipe_if
//   Handshake and data bundle for expr_lane_pipe.
//   master : operand sequencer side (drives beats in, accepts results out)
//   slave  : expr_lane_pipe side
// Signals:
//   in_valid/in_ready   : input beat handshake
//   op                  : 3-bit opcode per lane, lane i at [3i+2:3i]
//   a, b                : WIDTH-bit operands per lane, lane i at [WIDTH*i +: WIDTH]
//   a_signed, b_signed  : per-lane operand signedness
//   out_valid/out_ready : result beat handshake
//   y, ovf              : per-lane result and overflow flag
interface expr_lane_pipe_if #(
  parameter int WIDTH = 6,
  parameter int LANES = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3*LANES-1:0]       op;
  logic [WIDTH*LANES-1:0]   a;
  logic [WIDTH*LANES-1:0]   b;
  logic [LANES-1:0]         a_signed;
  logic [LANES-1:0]         b_signed;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*LANES-1:0]   y;
  logic [LANES-1:0]         ovf;

  modport master (
    output in_valid, op, a, b, a_signed, b_signed, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, op, a, b, a_signed, b_signed, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/expr_lane_pipe.sv
// expr_lane_pipe
//   Two-stage, LANES-wide expression evaluator with valid/ready flow control.
//   S1 registers operands/opcode/signedness, S2 registers y and ovf.
//   Latency 2, throughput 1 beat/cycle, capacity 2 beats, order preserved.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : expr_lane_pipe_if.slave (handshake, operands, results)
//   tx_count : accepted-beat counter, wraps silently
module expr_lane_pipe #(
  parameter int WIDTH = 6,
  parameter int LANES = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  expr_lane_pipe_if.slave   bus,
  output logic [CNT_W-1:0]  tx_count
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] W_AMT = WIDTH[WIDTH-1:0];

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3,
    OP_SHL = 3'd4, OP_SHR = 3'd5, OP_GE  = 3'd6, OP_MUL = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             ovf;
  } lane_res_t;

  // True when a 2*WIDTH result is the sign (signed) or zero (unsigned)
  // extension of its low WIDTH bits, i.e. nothing was lost by truncation.
  function automatic logic fits(input logic [W2-1:0] full, input logic sgn);
    logic [WIDTH:0]   top_s;
    logic [WIDTH-1:0] top_u;
    top_s = full[W2-1:WIDTH-1];
    top_u = full[W2-1:WIDTH];
    return sgn ? ((&top_s) || !(|top_s)) : !(|top_u);
  endfunction

  function automatic lane_res_t lane_eval(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sgn
  );
    logic [W2-1:0]    ax, bx, full;
    logic [WIDTH-1:0] r;
    logic             o;
    logic             big;
    // NOTE: every local gets a value before the case so no path leaves
    // anything unassigned; in always_comb the same habit avoids latches.
    full = '0;
    r    = '0;
    o    = 1'b0;
    ax   = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    bx   = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    big  = (b >= W_AMT);
    case (op_e'(op))
      OP_ADD: begin full = ax + bx; r = full[WIDTH-1:0]; o = !fits(full, sgn); end
      OP_SUB: begin full = ax - bx; r = full[WIDTH-1:0]; o = !fits(full, sgn); end
      OP_AND: r = a & b;
      OP_XOR: r = a ^ b;
      OP_SHL: begin
        // Shift amount is always unsigned; a full shift-out loses all of A.
        if (big) begin
          r = '0;
          o = |a;
        end else begin
          full = ax << b;
          r    = full[WIDTH-1:0];
          o    = !fits(full, sgn);
        end
      end
      OP_SHR: begin
        if (sgn) r = big ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
        else     r = big ? '0 : (a >> b);
      end
      OP_GE:  r = {{(WIDTH-1){1'b0}}, (sgn ? ($signed(a) >= $signed(b)) : (a >= b))};
      OP_MUL: begin full = ax * bx; r = full[WIDTH-1:0]; o = !fits(full, sgn); end
      default: r = '0;
    endcase
    return '{y: r, ovf: o};
  endfunction

  // Stage registers
  logic                   s1_valid_q;
  logic [3*LANES-1:0]     s1_op_q;
  logic [WIDTH*LANES-1:0] s1_a_q, s1_b_q;
  logic [LANES-1:0]       s1_sgn_q;
  logic                   s2_valid_q;
  logic [WIDTH*LANES-1:0] y_q, y_d;
  logic [LANES-1:0]       ovf_q, ovf_d;
  logic [CNT_W-1:0]       tx_q;

  logic s1_adv, s2_adv, accept;

  // Each stage moves when it is empty or the stage after it moves; the
  // ready chain is combinational from out_ready so a full pipe still
  // streams at one beat per cycle.
  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign accept       = bus.in_valid && s1_adv;
  assign bus.in_ready = s1_adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_res_t res;
    assign res                     = lane_eval(s1_op_q[3*i +: 3], s1_a_q[WIDTH*i +: WIDTH],
                                               s1_b_q[WIDTH*i +: WIDTH], s1_sgn_q[i]);
    assign y_d[WIDTH*i +: WIDTH]   = res.y;
    assign ovf_d[i]                = res.ovf;
  end

  // Control and result state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values of the others, matching real flip-flop behaviour.
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= '0;
      tx_q       <= '0;
    end else begin
      if (accept) tx_q <= tx_q + CNT_W'(1);
      if (s1_adv) s1_valid_q <= bus.in_valid;
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          y_q   <= y_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  // S1 operand capture.
  // NOTE: datapath registers carry no reset; s1_valid_q qualifies them, so
  // their power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q  <= bus.op;
      s1_a_q   <= bus.a;
      s1_b_q   <= bus.b;
      s1_sgn_q <= bus.a_signed & bus.b_signed;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign tx_count      = tx_q;

endmodule
